// File: rtl/image_pkg.sv
// Shared types and widths for the image scan path and downstream pixel stages.
package image_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned PIX_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [PIX_W-1:0]   r;
    logic [PIX_W-1:0]   g;
    logic [PIX_W-1:0]   b;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               sof;
    logic               eol;
    logic               eof;
  } pix_t;

endpackage

// File: rtl/image_scan_ctrl_if.sv
// Bundle between the scan controller, the image reader and the pixel sink.
interface image_scan_ctrl_if;
  import image_pkg::*;

  logic               START;
  logic               ABORT;
  logic [COORD_W-1:0] IMG_WIDTH;
  logic [COORD_W-1:0] IMG_HEIGHT;
  logic [PIX_W-1:0]   PIX_R;
  logic [PIX_W-1:0]   PIX_G;
  logic [PIX_W-1:0]   PIX_B;
  logic [COORD_W-1:0] ROW;
  logic [COORD_W-1:0] COL;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [PIX_W-1:0]   OUT_R;
  logic [PIX_W-1:0]   OUT_G;
  logic [PIX_W-1:0]   OUT_B;
  logic [COORD_W-1:0] OUT_ROW;
  logic [COORD_W-1:0] OUT_COL;
  logic               OUT_SOF;
  logic               OUT_EOL;
  logic               OUT_EOF;
  logic               BUSY;
  logic               DONE;
  logic               ERR;

  modport master (
    input  START, ABORT, IMG_WIDTH, IMG_HEIGHT, PIX_R, PIX_G, PIX_B, OUT_READY,
    output ROW, COL, OUT_VALID, OUT_R, OUT_G, OUT_B, OUT_ROW, OUT_COL,
           OUT_SOF, OUT_EOL, OUT_EOF, BUSY, DONE, ERR
  );

  modport slave (
    output START, ABORT, IMG_WIDTH, IMG_HEIGHT, PIX_R, PIX_G, PIX_B, OUT_READY,
    input  ROW, COL, OUT_VALID, OUT_R, OUT_G, OUT_B, OUT_ROW, OUT_COL,
           OUT_SOF, OUT_EOL, OUT_EOF, BUSY, DONE, ERR
  );

endinterface

// File: rtl/image_coord_counter.sv
// Row-major raster coordinate counter with end-of-line / end-of-frame detect.
module image_coord_counter
  import image_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic [COORD_W-1:0] w_last,
  input  logic [COORD_W-1:0] h_last,
  output logic [COORD_W-1:0] row_q,
  output logic [COORD_W-1:0] col_q,
  output logic               sof_c,
  output logic               eol_c,
  output logic               last_c
);

  logic [COORD_W-1:0] row_d;
  logic [COORD_W-1:0] col_d;

  assign sof_c  = (row_q == '0) && (col_q == '0);
  assign eol_c  = (col_q == w_last);
  assign last_c = eol_c && (row_q == h_last);

  // Next coordinate: clear wins, otherwise step with column wrap.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (eol_c) begin
        col_d = '0;
        row_d = row_q + COORD_W'(1);
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/image_scan_ctrl.sv
// Raster-scan sequencer: walks the reader address space and streams registered pixels.
module image_scan_ctrl
  import image_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = 1080,
  parameter int unsigned MAX_HEIGHT = 1080
) (
  input  logic               CLK,
  input  logic               RESET,
  image_scan_ctrl_if.master  bus
);

  scan_state_t        state_q, state_d;
  pix_t               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [COORD_W-1:0] w_last_q, w_last_d;
  logic [COORD_W-1:0] h_last_q, h_last_d;

  logic [COORD_W-1:0] row_q;
  logic [COORD_W-1:0] col_q;
  logic               sof_c, eol_c, last_c;
  logic               cnt_clear_c, cnt_advance_c;
  logic               size_bad_c;

  assign size_bad_c = (bus.IMG_WIDTH == '0) || (bus.IMG_HEIGHT == '0) ||
                      (bus.IMG_WIDTH  > COORD_W'(MAX_WIDTH)) ||
                      (bus.IMG_HEIGHT > COORD_W'(MAX_HEIGHT));

  image_coord_counter u_coord (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (cnt_clear_c),
    .advance (cnt_advance_c),
    .w_last  (w_last_q),
    .h_last  (h_last_q),
    .row_q   (row_q),
    .col_q   (col_q),
    .sof_c   (sof_c),
    .eol_c   (eol_c),
    .last_c  (last_c)
  );

  // Next-state, output-register load and counter control.
  always_comb begin
    state_d       = state_q;
    out_d         = out_q;
    valid_d       = valid_q;
    err_d         = err_q;
    w_last_d      = w_last_q;
    h_last_d      = h_last_q;
    cnt_clear_c   = 1'b0;
    cnt_advance_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          w_last_d    = bus.IMG_WIDTH - COORD_W'(1);
          h_last_d    = bus.IMG_HEIGHT - COORD_W'(1);
          cnt_clear_c = 1'b1;
          err_d       = size_bad_c;
          state_d     = size_bad_c ? FIN : SCAN;
        end
      end
      SCAN: begin
        if (bus.ABORT) begin
          valid_d = 1'b0;
          state_d = FIN;
        end else if (!valid_q || bus.OUT_READY) begin
          out_d = '{r: bus.PIX_R, g: bus.PIX_G, b: bus.PIX_B, row: row_q, col: col_q,
                    sof: sof_c, eol: eol_c, eof: last_c};
          valid_d = 1'b1;
          if (last_c) begin
            state_d = DRAIN;
          end else begin
            cnt_advance_c = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.ABORT) begin
          valid_d = 1'b0;
          state_d = FIN;
        end else if (valid_q && bus.OUT_READY) begin
          valid_d = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      out_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      w_last_q <= '0;
      h_last_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      w_last_q <= w_last_d;
      h_last_q <= h_last_d;
    end
  end

  assign bus.ROW       = row_q;
  assign bus.COL       = col_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT_R     = out_q.r;
  assign bus.OUT_G     = out_q.g;
  assign bus.OUT_B     = out_q.b;
  assign bus.OUT_ROW   = out_q.row;
  assign bus.OUT_COL   = out_q.col;
  assign bus.OUT_SOF   = out_q.sof;
  assign bus.OUT_EOL   = out_q.eol;
  assign bus.OUT_EOF   = out_q.eof;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Self-checking bench for image_scan_ctrl with a behavioural reader and frame model.
module tb_image_scan_ctrl;
  import image_pkg::*;

  localparam int unsigned MAXW = 1080;
  localparam int unsigned MAXH = 1080;

  logic       clk = 1'b0;
  logic       rst;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] seed = 8'd0;

  image_scan_ctrl_if bus();

  image_scan_ctrl #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader model: pixel colour is a function of address and a per-frame seed.
  function automatic logic [23:0] rgb(input logic [11:0] r, input logic [11:0] c, input logic [7:0] s);
    logic [7:0] pr, pg, pb;
    pr = 8'(32'(r) * 3 + 32'(s));
    pg = 8'(32'(c) * 7 + 32'(s) * 5);
    pb = 8'(32'(r) ^ 32'(c) ^ 32'(s));
    return {pr, pg, pb};
  endfunction

  assign {bus.PIX_R, bus.PIX_G, bus.PIX_B} = rgb(bus.ROW, bus.COL, seed);

  function automatic pix_t exp_pix(input int r, input int c, input int w, input int h);
    pix_t p;
    {p.r, p.g, p.b} = rgb(12'(r), 12'(c), seed);
    p.row = 12'(r);
    p.col = 12'(c);
    p.sof = (r == 0) && (c == 0);
    p.eol = (c == w - 1);
    p.eof = (r == h - 1) && (c == w - 1);
    return p;
  endfunction

  function automatic pix_t obs();
    pix_t p;
    p = '{r: bus.OUT_R, g: bus.OUT_G, b: bus.OUT_B, row: bus.OUT_ROW, col: bus.OUT_COL,
          sof: bus.OUT_SOF, eol: bus.OUT_EOL, eof: bus.OUT_EOF};
    return p;
  endfunction

  function automatic logic [100:0] all_outs();
    return {bus.ROW, bus.COL, bus.OUT_VALID, bus.OUT_R, bus.OUT_G, bus.OUT_B, bus.OUT_ROW,
            bus.OUT_COL, bus.OUT_SOF, bus.OUT_EOL, bus.OUT_EOF, bus.BUSY, bus.DONE, bus.ERR};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; rdy_pct<0 selects the fixed 1,0,0,1,0,1 ready pattern.
  task automatic do_frame(input int w, input int h, input int rdy_pct, input int abort_at,
                          input bit extra_start, input string tag);
    pix_t q[$];
    pix_t held;
    int   pat[6] = '{1, 0, 0, 1, 0, 1};
    int   t, idx, last_acc, done_cyc, first_valid, abort_cyc;
    bit   rdy, stalled, aborted, abort_now;
    idx = 0; last_acc = -1; done_cyc = -1; first_valid = -1; abort_cyc = -1;
    stalled = 1'b0; aborted = 1'b0; held = '0;
    seed = 8'($urandom);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        q.push_back(exp_pix(r, c, w, h));

    bus.IMG_WIDTH  = 12'(w);
    bus.IMG_HEIGHT = 12'(h);
    bus.START      = 1'b1;
    bus.OUT_READY  = 1'b0;
    t = cyc;
    tick();
    bus.START      = 1'b0;
    bus.IMG_WIDTH  = 12'($urandom);
    bus.IMG_HEIGHT = 12'($urandom);
    n_cmp++;
    if (bus.BUSY !== 1'b1 || bus.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after_start: got busy=%b err=%b required busy=1 err=0", tag, bus.BUSY, bus.ERR);
    end

    for (int k = 0; k < 4000 && done_cyc < 0; k++) begin
      if (bus.DONE === 1'b1) begin
        done_cyc = cyc;
      end else begin
        abort_now = (abort_at >= 0) && (idx == abort_at) && !aborted && (bus.OUT_VALID === 1'b1);
        if (rdy_pct < 0) rdy = pat[k % 6] != 0;
        else             rdy = $urandom_range(99) < 32'(rdy_pct);
        if (abort_now) begin
          rdy = 1'b0;
          aborted = 1'b1;
          abort_cyc = cyc;
        end
        bus.OUT_READY = rdy;
        bus.ABORT     = abort_now;
        bus.START     = extra_start && (k == 3);
        if (stalled) begin
          n_cmp++;
          if (bus.OUT_VALID !== 1'b1 || obs() !== held) begin
            n_bad++;
            $display("FAIL %s stall_hold: got v=%b %h required v=1 %h", tag, bus.OUT_VALID, obs(), held);
          end
        end
        if (bus.OUT_VALID === 1'b1 && first_valid < 0) first_valid = cyc;
        if (bus.OUT_VALID === 1'b1 && rdy) begin
          n_cmp++;
          if (idx >= q.size()) begin
            n_bad++;
            $display("FAIL %s extra_pixel: got %h required none", tag, obs());
          end else if (obs() !== q[idx]) begin
            n_bad++;
            $display("FAIL %s pixel%0d: got %h required %h", tag, idx, obs(), q[idx]);
          end
          idx++;
          last_acc = cyc;
        end
        stalled = (bus.OUT_VALID === 1'b1) && !rdy && !abort_now;
        held = obs();
        tick();
      end
    end
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
    bus.OUT_READY = 1'b0;

    n_cmp++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL %s done_timeout: got no DONE required DONE", tag);
    end else if (aborted) begin
      if (done_cyc != abort_cyc + 1 || bus.OUT_VALID !== 1'b0 || idx != abort_at) begin
        n_bad++;
        $display("FAIL %s abort_done: got done@%0d v=%b n=%0d required done@%0d v=0 n=%0d",
                 tag, done_cyc, bus.OUT_VALID, idx, abort_cyc + 1, abort_at);
      end
    end else if (idx != w * h || done_cyc != last_acc + 1) begin
      n_bad++;
      $display("FAIL %s frame_done: got n=%0d done@%0d required n=%0d done@%0d",
               tag, idx, done_cyc, w * h, last_acc + 1);
    end

    n_cmp++;
    if (first_valid != t + 2) begin
      n_bad++;
      $display("FAIL %s first_valid: got cycle %0d required %0d", tag, first_valid, t + 2);
    end

    tick();
    n_cmp++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: got busy=%b done=%b err=%b v=%b required 0 0 0 0",
               tag, bus.BUSY, bus.DONE, bus.ERR, bus.OUT_VALID);
    end
    if (rdy_pct == 100 && !aborted) begin
      n_cmp++;
      if (cyc - t != w * h + 3) begin
        n_bad++;
        $display("FAIL %s frame_cycles: got %0d required %0d", tag, cyc - t, w * h + 3);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.OUT_READY = 1'b0;
    bus.IMG_WIDTH = '0; bus.IMG_HEIGHT = '0;
    tick(); tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got %h required 0", all_outs());
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_size_err(input int w, input int h, input string tag);
    bus.IMG_WIDTH = 12'(w); bus.IMG_HEIGHT = 12'(h); bus.START = 1'b1; bus.OUT_READY = 1'b1;
    tick();
    bus.START = 1'b0;
    n_cmp++;
    if (bus.ERR !== 1'b1 || bus.DONE !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL %s reject: got err=%b done=%b v=%b required 1 1 0", tag, bus.ERR, bus.DONE, bus.OUT_VALID);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.ERR !== 1'b1 || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
        n_bad++;
        $display("FAIL %s err_hold: got err=%b done=%b busy=%b v=%b required 1 0 0 0",
                 tag, bus.ERR, bus.DONE, bus.BUSY, bus.OUT_VALID);
      end
    end
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    seed = 8'($urandom);
    bus.IMG_WIDTH = 12'd4; bus.IMG_HEIGHT = 12'd3; bus.START = 1'b1; bus.OUT_READY = 1'b1;
    tick();
    bus.START = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_values: got %h required 0", all_outs());
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset_quiet: got done=%b busy=%b v=%b required 0 0 0",
                 bus.DONE, bus.BUSY, bus.OUT_VALID);
      end
    end
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 8; i++)
      do_frame(int'($urandom_range(6, 1)), int'($urandom_range(5, 1)),
               int'($urandom_range(100, 30)), -1, 1'b0, "rand_frame");
  endtask

  initial begin
    rst = 1'b1;
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.OUT_READY = 1'b0;
    bus.IMG_WIDTH = '0; bus.IMG_HEIGHT = '0;
    test_reset();
    do_frame(4, 3, 100, -1, 1'b0, "frame_4x3");
    do_frame(2, 2, -1, -1, 1'b0, "bp_2x2");
    do_frame(2, 2, 50, -1, 1'b0, "bp_rand_2x2");
    test_size_err(0, 3, "w_zero");
    do_frame(3, 2, 100, -1, 1'b0, "err_clear");
    test_size_err(5, int'(MAXH) + 1, "h_over");
    test_size_err(int'(MAXW) + 1, 2, "w_over");
    do_frame(4, 3, 100, 5, 1'b0, "abort_4x3");
    do_frame(4, 3, 100, -1, 1'b0, "after_abort");
    test_reset_mid_frame();
    do_frame(4, 3, 100, -1, 1'b1, "start_busy");
    do_frame(1, 1, 100, -1, 1'b0, "frame_1x1");
    do_frame(1, 4, 70, -1, 1'b0, "frame_1x4");
    do_frame(int'(MAXW), 1, 100, -1, 1'b0, "frame_maxw");
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_scan_ctrl.md
# image_scan_ctrl

Raster-scan sequencer for the BMP image reader. On a start command it latches the reader's reported WIDTH/HEIGHT and drives ROW/COL through every pixel in row-major order, top row first. It captures the reader's combinational RGB output into a registered pixel stream with valid/ready backpressure and frame markers. It sits between the image reader and downstream pixel-processing stages, and it is the only block that drives the reader's address inputs.

## Interface
Parameters:
- MAX_WIDTH, 1080, largest legal frame width
- MAX_HEIGHT, 1080, largest legal frame height

Ports:
- CLK  in  1  clock; the block has one clock domain
- RESET  in  1  synchronous, active-high reset
- START  in  1  frame request; sampled only in IDLE
- ABORT  in  1  cancels the frame in progress
- IMG_WIDTH  in  12  WIDTH from the reader
- IMG_HEIGHT  in  12  HEIGHT from the reader
- PIX_R, PIX_G, PIX_B  in  8 each  RED/GREEN/BLUE from the reader (combinational in ROW/COL)
- ROW  out  12  row address to the reader
- COL  out  12  column address to the reader
- OUT_VALID  out  1  output pixel valid
- OUT_READY  in  1  downstream accept
- OUT_R, OUT_G, OUT_B  out  8 each  pixel data
- OUT_ROW, OUT_COL  out  12 each  coordinates of the output pixel
- OUT_SOF  out  1  pixel (0,0)
- OUT_EOL  out  1  last column of a row
- OUT_EOF  out  1  last pixel of the frame
- BUSY  out  1  state is not IDLE
- DONE  out  1  one-cycle pulse when a frame completes, aborts or is rejected
- ERR  out  1  size error flag; holds until the next accepted START

## Operation
- States: IDLE, SCAN, DRAIN, FIN.
- **IDLE:**
  - On START, latch W=IMG_WIDTH and H=IMG_HEIGHT, set ROW=COL=0 and clear ERR.
  - If W==0, H==0, W>MAX_WIDTH or H>MAX_HEIGHT, set ERR and go to FIN. No pixels are produced.
  - Otherwise go to SCAN.
- **load = (state==SCAN) && (!OUT_VALID || OUT_READY).** On load:
  - OUT_* takes PIX_* plus the current ROW/COL and the flags.
  - OUT_VALID is set.
  - The coordinates advance: COL+1. When COL==W-1, COL=0 and ROW+1.
  - A load at (H-1,W-1) does not advance the coordinates and goes to DRAIN.
- When OUT_VALID && OUT_READY with no load in the same cycle, OUT_VALID is cleared.
- **DRAIN:** when OUT_VALID && OUT_READY, clear OUT_VALID and go to FIN.
- **FIN:** DONE=1 for one cycle, then IDLE.
- **ABORT** in SCAN or DRAIN has priority over load and accept:
  - Clear OUT_VALID and go to FIN.
  - ERR is unchanged.
  - ABORT in IDLE or FIN is ignored.
- START outside IDLE is ignored; it is not queued.
- OUT_* data and flags are held stable while OUT_VALID && !OUT_READY.
- **Flag definitions:**
  - OUT_SOF = (row==0 && col==0).
  - OUT_EOL = (col==W-1).
  - OUT_EOF = (row==H-1 && col==W-1).
  - For W==1, every pixel has EOL set. A 1×1 frame has SOF, EOL and EOF all set.
- **Arithmetic:**
  - Coordinates are 12-bit unsigned.
  - Comparisons use the latched W-1 and H-1, which are never 0-1 because zero sizes are rejected.
  - A change on IMG_WIDTH/IMG_HEIGHT after START does not affect the frame in progress.

## Timing
- Reset values: ROW=0, COL=0, OUT_VALID=0, OUT_R/G/B=0, OUT_ROW=0, OUT_COL=0, OUT_SOF/EOL/EOF=0, BUSY=0, DONE=0, ERR=0, state IDLE.
- RESET asserted mid-frame returns every output to these values on the next edge. No DONE pulse is generated.
- START is high in cycle t (IDLE):
  - BUSY=1 from t+1.
  - OUT_VALID=1 with pixel (0,0) from t+2.
- With OUT_READY held at 1, throughput is one pixel per cycle.
- Last pixel is accepted in cycle u: DONE=1 in u+1 and BUSY=0 in u+2.
- A complete W×H frame with OUT_READY held at 1 takes W·H+3 cycles from the START cycle to the first cycle with BUSY=0.
- Rejected START in cycle t: ERR=1 and DONE=1 in t+1.
- ABORT in cycle a: OUT_VALID=0 and DONE=1 in a+1.
- ROW/COL are registered. The reader path is combinational and must meet one cycle from ROW/COL to the OUT_* capture.

## Structure
- Shared package image_pkg:
  - COORD_W=12 and PIX_W=8.
  - State enum scan_state_t {IDLE, SCAN, DRAIN, FIN}.
  - The pixel struct {r, g, b, row, col, sof, eol, eof}, for reuse by downstream stages.
- One natural sub-module: image_coord_counter.
  - Holds the row/col registers, wrap logic and last/eol detection.
  - Controls: clear, advance, latched W/H.
- The FSM and output register stay in image_scan_ctrl.

## Test plan
- **4×3 frame, OUT_READY=1:** 12 pixels in (0,0),(0,1)…(2,3) order. EOL on col 3, SOF on first, EOF on 12th only. DONE 1 cycle after the 12th accept. BUSY low 15 cycles after START.
- **Backpressure on a 2×2 frame:** toggle OUT_READY 1,0,0,1,0,1… Each pixel is delivered exactly once. OUT_* is stable while stalled, with no skips or duplicates.
- **Size errors:** START with W=0, and separately H=MAX_HEIGHT+1. ERR=1 and DONE in the next cycle, OUT_VALID never asserted. The next valid START clears ERR.
- **ABORT:** 4×3 frame, ABORT after pixel 5. OUT_VALID=0 and DONE next cycle, then IDLE. A following START restarts at (0,0).
- **RESET mid-frame:** all outputs take their reset values on the next edge, with no DONE pulse.
- **START while BUSY:** the extra START is ignored and the frame pixel count is unchanged.
- **1×1 frame:** a single pixel with SOF, EOL and EOF all set.
